// File: rtl/regfile_pkg.sv
// Shared sizing and the packed register-array type handed to the read muxes.
package regfile_pkg;
  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [NREGS-1:0][WIDTH-1:0] reg_array_t;
endpackage

// File: rtl/decoder_5to32.sv
// Enabled 5-to-32 one-hot decoder: a 2-to-4 stage on sel[4:3] picks one of four 3-to-8 banks.
module decoder_5to32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  logic [3:0] bank;

  assign bank = en ? (4'b0001 << sel[4:3]) : 4'b0000;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign out[b*8 +: 8] = bank[b] ? (8'b0000_0001 << sel[2:0]) : 8'b0000_0000;
  end
endmodule

// File: rtl/mux_2to1.sv
// Single-bit 2:1 multiplexer; used as the hold/load selector on each storage bit.
module mux_2to1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic out
);
  assign out = sel ? i1 : i0;
endmodule

// File: rtl/mux_64w32to1.sv
// 32-way, 64-bit-wide read multiplexer over the packed register array.
module mux_64w32to1
  import regfile_pkg::*;
(
  input  reg_array_t       data,
  input  logic [4:0]       sel,
  output logic [WIDTH-1:0] out
);
  assign out = data[sel];
endmodule

// File: rtl/register_file_64x32.sv
// LEGv8 architectural register file: 31 writable 64-bit registers plus XZR,
// one synchronous write port and two combinational read ports without forwarding.
module register_file_64x32
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);
  logic [NREGS-1:0] wr_en;
  reg_array_t       regs;
  logic             unused_zero_en;

  decoder_5to32 u_dec (
    .en  (RegWrite),
    .sel (WriteRegister),
    .out (wr_en)
  );

  for (genvar r = 0; r < ZERO_REG; r++) begin : g_reg
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      mux_2to1 u_hold (
        .i0  (q[b]),
        .i1  (WriteData[b]),
        .sel (wr_en[r]),
        .out (d[b])
      );
    end

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
    end

    assign regs[r] = q;
  end

  // XZR has no storage, so its decoder enable goes nowhere.
  assign regs[ZERO_REG] = '0;
  assign unused_zero_en = wr_en[ZERO_REG];

  mux_64w32to1 u_rd1 (
    .data (regs),
    .sel  (ReadRegister1),
    .out  (ReadData1)
  );

  mux_64w32to1 u_rd2 (
    .data (regs),
    .sel  (ReadRegister2),
    .out  (ReadData2)
  );
endmodule

// File: tb/tb_register_file_64x32.sv
// Self-checking bench for register_file_64x32: array model, per-cycle compare, directed and random stimulus.
module tb_register_file_64x32;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int checks = 0;
  int fails  = 0;
  bit model_valid = 1'b0;
  logic [63:0] model [32];

  register_file_64x32 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  // Model: a plain array of architectural values; X31 is never stored.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 64'd0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [63:0] model_read(input logic [4:0] sel);
    return (sel == 5'd31) ? 64'd0 : model[sel];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both read ports against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_rd1", ReadData1, model_read(ReadRegister1));
      check("model_rd2", ReadData2, model_read(ReadRegister2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
    RegWrite = 1'b1; WriteRegister = idx; WriteData = val;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] r1, input logic [4:0] r2);
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp2;
    logic [4:0]  r2;

    // Initial reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_valid = 1'b1;
    set_reads(5'd0, 5'd30);
    check("reset_x0", ReadData1, 64'd0);
    check("reset_x30", ReadData2, 64'd0);

    // Test 1: fill with nonzero data, reset, everything reads zero
    for (int i = 0; i < 31; i++) write_reg(5'(i), {$urandom, $urandom} | 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(i));
      check("clear_rd1", ReadData1, 64'd0);
      check("clear_rd2", ReadData2, 64'd0);
    end

    // Test 2: walk every register, port 2 offset by one
    for (int i = 0; i < 31; i++) write_reg(5'(i), 64'hA5A5_0000_0000_0000 | 64'(i));
    for (int i = 0; i < 32; i++) begin
      r2 = 5'((i + 1) % 32);
      set_reads(5'(i), r2);
      check("walk_rd1", ReadData1, (i == 31) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(i)));
      exp2 = (r2 == 5'd31) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(r2));
      check("walk_rd2", ReadData2, exp2);
    end

    // Test 3: XZR ignores writes, others unchanged
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    set_reads(5'd31, 5'd30);
    check("xzr_rd1", ReadData1, 64'd0);
    check("xzr_x30", ReadData2, 64'hA5A5_0000_0000_001E);
    set_reads(5'd0, 5'd15);
    check("xzr_x0", ReadData1, 64'hA5A5_0000_0000_0000);
    check("xzr_x15", ReadData2, 64'hA5A5_0000_0000_000F);

    // Test 4: RegWrite gating
    write_reg(5'd5, 64'hDEAD);
    RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'h1234;
    tick();
    set_reads(5'd5, 5'd5);
    check("gate_x5", ReadData1, 64'hDEAD);

    // Test 5: read-during-write, then reset priority over write
    write_reg(5'd7, 64'h1111);
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h2222;
    set_reads(5'd7, 5'd7);
    check("rdw_before", ReadData1, 64'h1111);
    tick();
    RegWrite = 1'b0;
    #1;
    check("rdw_after", ReadData1, 64'h2222);
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h3333;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    #1;
    check("rst_prio_x7", ReadData1, 64'd0);

    // Back-to-back writes to one register: last wins
    write_reg(5'd9, 64'hAAAA);
    write_reg(5'd9, 64'hBBBB);
    set_reads(5'd9, 5'd9);
    check("b2b_x9", ReadData2, 64'hBBBB);

    // Random traffic, occasional mid-stream reset
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      RegWrite      = $urandom_range(0, 3) != 0;
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = {$urandom, $urandom};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0; RegWrite = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
